// File: rtl/ib_trace_arbiter_if.sv
// ---------------------------------------------------------------------------
// ib_trace_arbiter_if
// Bundles the trace-source handshake and the input-buffer write port of the
// trace arbiter.
//   src_valid/src_eof/src_vector : beats offered by each trace source
//   src_ready                    : per-source accept (valid & ready)
//   ib_deq                       : buffer popped one entry this cycle
//   ib_enqueue/ib_eof/ib_vector  : registered write into the input buffer
// Modports: slave = arbiter view, master = probe/buffer side view.
// ---------------------------------------------------------------------------
interface ib_trace_arbiter_if #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 2
);
    logic [NUM_SRC-1:0]                          src_valid;
    logic [NUM_SRC-1:0]                          src_eof;
    logic [NUM_SRC-1:0][N-1:0][DATA_WIDTH-1:0]   src_vector;
    logic [NUM_SRC-1:0]                          src_ready;
    logic                                        ib_deq;
    logic                                        ib_enqueue;
    logic                                        ib_eof;
    logic [N-1:0][DATA_WIDTH-1:0]                ib_vector;

    modport slave (
        input  src_valid, src_eof, src_vector, ib_deq,
        output src_ready, ib_enqueue, ib_eof, ib_vector
    );

    modport master (
        output src_valid, src_eof, src_vector, ib_deq,
        input  src_ready, ib_enqueue, ib_eof, ib_vector
    );
endinterface

// File: rtl/ib_trace_arbiter.sv
// ---------------------------------------------------------------------------
// ib_trace_arbiter
// Shares the input buffer between NUM_SRC trace sources. Arbitrates once per
// frame, holds the owner until its eof beat is accepted, tracks free buffer
// entries so the buffer is never written while full, and owns the trace
// enable / priority-mode config register.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   bus          : source handshake + buffer write port (slave modport)
//   config_id    : config address, register loads when it equals CFG_ID
//   config_data  : [0]=trace_en [1]=prio_mode (0 round-robin, 1 fixed src0)
//   ib_tracing   : current trace_en
//   grant_id     : owner of the current / last frame
//   credits      : free buffer entries (0..IB_DEPTH-1)
//
// state | meaning
// IDLE  | no owner; arbitrate when tracing and any source valid
// BUSY  | owner streams beats, back to IDLE on accepted eof
// DRAIN | tracing dropped mid-frame; owner finishes its frame, then IDLE
// ---------------------------------------------------------------------------
module ib_trace_arbiter #(
    parameter int         N          = 8,
    parameter int         DATA_WIDTH = 32,
    parameter int         IB_DEPTH   = 4,
    parameter int         NUM_SRC    = 2,
    parameter logic [7:0] CFG_ID     = 8'd1,
    localparam int        PTR_W      = $clog2(NUM_SRC),
    localparam int        CRED_W     = $clog2(IB_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ib_trace_arbiter_if.slave    bus,
    input  logic [7:0]           config_id,
    input  logic [7:0]           config_data,
    output logic                 ib_tracing,
    output logic [PTR_W-1:0]     grant_id,
    output logic [CRED_W-1:0]    credits
);

    localparam logic [CRED_W-1:0] MAX_CRED = CRED_W'(IB_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                        state, state_nxt;
    logic                          trace_en;
    logic                          prio_mode;
    logic [PTR_W-1:0]              rr_ptr;
    logic [PTR_W-1:0]              grant_nxt;
    logic [PTR_W-1:0]              winner;
    logic                          found;
    int                            idx;
    logic [NUM_SRC-1:0]            ready;
    logic                          accept;
    logic                          acc_eof;
    logic                          enq_q;
    logic                          eof_q;
    logic [N-1:0][DATA_WIDTH-1:0]  vec_q;
    logic                          unused_cfg;

    assign unused_cfg     = ^config_data[7:2];
    assign ib_tracing     = trace_en;
    assign bus.src_ready  = ready;
    assign bus.ib_enqueue = enq_q;
    assign bus.ib_eof     = eof_q;
    assign bus.ib_vector  = vec_q;

    // Winner selection: fixed mode takes the lowest valid index, round-robin
    // scans upward from rr_ptr with wrap.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        if (prio_mode) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!found && bus.src_valid[i]) begin
                    winner = PTR_W'(i);
                    found  = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                idx = int'(rr_ptr) + i;
                if (idx >= NUM_SRC) idx = idx - NUM_SRC;
                if (!found && bus.src_valid[idx]) begin
                    winner = PTR_W'(idx);
                    found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        ready     = '0;
        accept    = 1'b0;
        acc_eof   = 1'b0;
        case (state)
            IDLE: begin
                if (trace_en && found) begin
                    grant_nxt = winner;
                    state_nxt = BUSY;
                end
            end
            BUSY, DRAIN: begin
                // Ready is masked at zero credits so the buffer never overflows.
                if (bus.src_valid[grant_id] && (credits != '0)) begin
                    ready[grant_id] = 1'b1;
                    accept          = 1'b1;
                    acc_eof         = bus.src_eof[grant_id];
                end
                if (acc_eof) begin
                    state_nxt = IDLE;
                end else if (state == BUSY && !trace_en) begin
                    state_nxt = DRAIN;
                end else if (state == DRAIN && trace_en) begin
                    state_nxt = BUSY;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            trace_en  <= 1'b0;
            prio_mode <= 1'b0;
            rr_ptr    <= '0;
            grant_id  <= '0;
            credits   <= MAX_CRED;
        end else begin
            state    <= state_nxt;
            grant_id <= grant_nxt;
            if (acc_eof) begin
                rr_ptr <= (grant_id == PTR_W'(NUM_SRC - 1)) ? '0 : grant_id + 1'b1;
            end
            if (config_id == CFG_ID) begin
                trace_en  <= config_data[0];
                prio_mode <= config_data[1];
            end
            // Simultaneous accept and pop leaves the count unchanged; a pop
            // while already at the maximum is ignored.
            case ({accept, bus.ib_deq})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   if (credits != MAX_CRED) credits <= credits + 1'b1;
                default: credits <= credits;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enq_q <= 1'b0;
            eof_q <= 1'b0;
            vec_q <= '0;
        end else begin
            enq_q <= accept;
            eof_q <= acc_eof;
            if (accept) vec_q <= bus.src_vector[grant_id];
        end
    end

endmodule

// File: tb/tb_ib_trace_arbiter.sv
module tb_ib_trace_arbiter;
    localparam int N     = 8;
    localparam int DW    = 32;
    localparam int NS    = 2;
    localparam int DEPTH = 4;
    localparam int MAXC  = DEPTH - 1;

    typedef logic [N-1:0][DW-1:0] vec_t;
    typedef struct packed {
        logic eof;
        vec_t vec;
    } item_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] config_id;
    logic [7:0] config_data;
    logic       ib_tracing;
    logic [0:0] grant_id;
    logic [2:0] credits;

    ib_trace_arbiter_if #(.N(N), .DATA_WIDTH(DW), .NUM_SRC(NS)) bus ();

    ib_trace_arbiter #(.N(N), .DATA_WIDTH(DW), .IB_DEPTH(DEPTH), .NUM_SRC(NS), .CFG_ID(8'd1)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .config_id(config_id),
        .config_data(config_data),
        .ib_tracing(ib_tracing),
        .grant_id(grant_id),
        .credits(credits)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int enq_total = 0;
    int eof_total = 0;

    item_t   exp_q[$];
    longint  exp_t[$];

    // reference model: frame ownership and buffer occupancy
    int m_owner = -1;
    int m_cred  = MAXC;
    int m_rr    = 0;
    int m_grant = 0;
    int m_beats = 0;
    bit m_tracing = 1'b0;
    bit m_prio    = 1'b0;

    // source drivers
    bit          drv_valid[NS];
    int          drv_left[NS];
    int          drv_frames[NS];
    vec_t        drv_vec[NS];
    int          drv_prob  = 100;
    int          fixed_len = 0;
    int          deq_mode  = 1;
    bit          deq_pulse = 1'b0;
    logic [NS-1:0] acc_dut = '0;

    bit         cfg_req = 1'b0;
    logic [7:0] cfg_id_v, cfg_val;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // scoreboard monitor
    initial begin
        item_t  e;
        longint t;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.ib_enqueue !== 1'b0) begin
                enq_total++;
                if (bus.ib_eof === 1'b1) eof_total++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL enq_unexpected: got enqueue eof=%0b lane0=%h expected none at %0t",
                             bus.ib_eof, bus.ib_vector[0], $time);
                end else begin
                    e = exp_q.pop_front();
                    t = exp_t.pop_front();
                    if (bus.ib_eof !== e.eof || bus.ib_vector !== e.vec || ($time - t) != 10) begin
                        miscompares++;
                        $display("FAIL enq_beat: got eof=%0b lane0=%h lane7=%h lat=%0t expected eof=%0b lane0=%h lane7=%h lat=10",
                                 bus.ib_eof, bus.ib_vector[0], bus.ib_vector[N-1], $time - t,
                                 e.eof, e.vec[0], e.vec[N-1]);
                    end
                end
            end
        end
    end

    task automatic model_step();
        logic [NS-1:0] exp_rdy;
        bit acc, aeof;
        int w, j;
        exp_rdy = '0;
        acc = 1'b0;
        aeof = 1'b0;
        if (m_owner >= 0) begin
            if (bus.src_valid[m_owner] && m_cred > 0) begin
                exp_rdy[m_owner] = 1'b1;
                acc  = 1'b1;
                aeof = bus.src_eof[m_owner];
            end
        end
        chk("src_ready", 64'(bus.src_ready), 64'(exp_rdy));
        chk("credits", 64'(credits), 64'(m_cred));
        chk("grant_id", 64'(grant_id), 64'(m_grant));
        chk("ib_tracing", 64'(ib_tracing), 64'(m_tracing));
        acc_dut = bus.src_ready & bus.src_valid;
        if (acc) begin
            exp_q.push_back({aeof, bus.src_vector[m_owner]});
            exp_t.push_back($time);
            m_beats++;
        end
        if (acc && !bus.ib_deq) m_cred--;
        else if (!acc && bus.ib_deq && m_cred < MAXC) m_cred++;
        if (acc && aeof) begin
            m_rr = (m_owner + 1) % NS;
            m_owner = -1;
        end else if (m_owner < 0 && m_tracing && bus.src_valid != '0) begin
            w = -1;
            for (int k = 0; k < NS; k++) begin
                j = m_prio ? k : (m_rr + k) % NS;
                if (w < 0 && bus.src_valid[j]) w = j;
            end
            m_owner = w;
            m_grant = w;
            m_beats = 0;
        end
        if (config_id == 8'd1) begin
            m_tracing = config_data[0];
            m_prio    = config_data[1];
        end
    endtask

    task automatic drive_sources();
        for (int i = 0; i < NS; i++) begin
            if (drv_valid[i] && acc_dut[i]) begin
                drv_valid[i] = 1'b0;
                drv_left[i]--;
            end
            if (!drv_valid[i]) begin
                if (drv_left[i] == 0 && drv_frames[i] > 0 && int'($urandom_range(0, 99)) < drv_prob) begin
                    drv_left[i] = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 5));
                    drv_frames[i]--;
                end
                if (drv_left[i] > 0 && int'($urandom_range(0, 99)) < drv_prob) begin
                    drv_valid[i] = 1'b1;
                    for (int l = 0; l < N; l++) drv_vec[i][l] = $urandom;
                end
            end
            bus.src_valid[i]  = drv_valid[i];
            bus.src_eof[i]    = drv_valid[i] && drv_left[i] == 1;
            bus.src_vector[i] = drv_vec[i];
        end
        acc_dut = '0;
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        config_id = 8'd0;
        if (cfg_req) begin
            config_id   = cfg_id_v;
            config_data = cfg_val;
            cfg_req     = 1'b0;
        end
        case (deq_mode)
            0:       bus.ib_deq = deq_pulse;
            1:       bus.ib_deq = 1'b1;
            default: bus.ib_deq = 1'($urandom_range(0, 1));
        endcase
        deq_pulse = 1'b0;
        drive_sources();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic cfg(input logic [7:0] id, input logic [7:0] val);
        cfg_req  = 1'b1;
        cfg_id_v = id;
        cfg_val  = val;
        cycle();
    endtask

    task automatic clear_drivers();
        for (int i = 0; i < NS; i++) begin
            drv_valid[i]  = 1'b0;
            drv_left[i]   = 0;
            drv_frames[i] = 0;
            drv_vec[i]    = '0;
        end
        bus.src_valid  = '0;
        bus.src_eof    = '0;
        bus.src_vector = '0;
        acc_dut        = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ib_enqueue"}, 64'(bus.ib_enqueue), 64'd0);
        chk({tag, "_ib_eof"}, 64'(bus.ib_eof), 64'd0);
        chk({tag, "_ib_vector_nonzero"}, 64'(|bus.ib_vector), 64'd0);
        chk({tag, "_src_ready"}, 64'(bus.src_ready), 64'd0);
        chk({tag, "_credits"}, 64'(credits), 64'(MAXC));
        chk({tag, "_ib_tracing"}, 64'(ib_tracing), 64'd0);
        chk({tag, "_grant_id"}, 64'(grant_id), 64'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < NS; i++) drv_frames[i] = 0;
        fixed_len = 0;
        drv_prob  = 100;
        deq_mode  = 1;
        cfg(8'd1, 8'h01);
        run(40);
    endtask

    // wait (bounded) until src0 owns a frame and has delivered two beats
    task automatic wait_two_beats(input string tag);
        int n;
        n = 0;
        while (!(m_owner == 0 && m_beats >= 2) && n < 30) begin
            cycle();
            n++;
        end
        chk({tag, "_two_beats_reached"}, 64'(m_owner == 0 && m_beats >= 2), 64'd1);
    endtask

    initial begin
        int e0, f0;
        config_id   = 8'd0;
        config_data = 8'd0;
        bus.ib_deq  = 1'b0;
        clear_drivers();

        // power-up reset
        #22;
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // single 3-beat frame from src0, buffer always draining
        drv_frames[0] = 1;
        fixed_len = 3;
        deq_mode  = 1;
        e0 = enq_total;
        f0 = eof_total;
        cfg(8'd1, 8'h01);
        run(12);
        chk("t1_beats", 64'(enq_total - e0), 64'd3);
        chk("t1_eof", 64'(eof_total - f0), 64'd1);
        chk("t1_grant", 64'(grant_id), 64'd0);

        // round-robin with continuous single-beat frames, then fixed priority
        drv_frames[0] = 30;
        drv_frames[1] = 30;
        fixed_len = 1;
        run(20);
        cfg(8'd1, 8'h03);
        run(20);
        drain();

        // backpressure: no pops, 5-beat frame
        deq_mode = 0;
        drv_frames[0] = 1;
        fixed_len = 5;
        e0 = enq_total;
        run(12);
        chk("t3_credits_empty", 64'(credits), 64'd0);
        chk("t3_beats_stalled", 64'(enq_total - e0), 64'd3);
        chk("t3_ready_masked", 64'(bus.src_ready), 64'd0);
        deq_pulse = 1'b1;
        run(6);
        chk("t3_beats_after_pop", 64'(enq_total - e0), 64'd4);
        chk("t3_credits_after_pop", 64'(credits), 64'd0);
        deq_mode = 1;
        run(20);
        chk("t3_beats_final", 64'(enq_total - e0), 64'd5);

        // disable tracing mid-frame: frame completes, no new grant
        drv_frames[0] = 1;
        fixed_len = 4;
        e0 = enq_total;
        wait_two_beats("t4");
        drv_frames[1] = 1;
        cfg(8'd1, 8'h00);
        run(15);
        chk("t4_frame_complete", 64'(enq_total - e0), 64'd4);
        chk("t4_no_new_grant", 64'(grant_id), 64'd0);
        chk("t4_idle_ready", 64'(bus.src_ready), 64'd0);
        cfg(8'd1, 8'h01);
        run(15);
        chk("t4_src1_served", 64'(enq_total - e0), 64'd8);

        // randomized traffic, random pops, occasional config writes
        drv_prob  = 60;
        fixed_len = 0;
        deq_mode  = 2;
        for (int i = 0; i < NS; i++) drv_frames[i] = 1000000;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 99) < 3) begin
                case ($urandom_range(0, 3))
                    0, 1: cfg(8'd1, {6'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) != 0)});
                    2:    cfg(8'd2, 8'h00);
                    default: cfg(8'h81, 8'($urandom));
                endcase
            end else begin
                cycle();
            end
        end
        drain();

        // asynchronous reset in the middle of a frame
        drv_frames[0] = 1;
        fixed_len = 5;
        deq_mode  = 1;
        wait_two_beats("t6");
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("t6");
        clear_drivers();
        exp_q.delete();
        exp_t.delete();
        m_owner = -1; m_cred = MAXC; m_rr = 0; m_grant = 0; m_beats = 0;
        m_tracing = 1'b0; m_prio = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        drv_frames[0] = 1;
        fixed_len = 2;
        e0 = enq_total;
        run(10);
        chk("t6_no_trace_after_reset", 64'(enq_total - e0), 64'd0);
        cfg(8'd1, 8'h01);
        run(10);
        chk("t6_frame_after_enable", 64'(enq_total - e0), 64'd2);

        drain();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
